serial_subtractor: RTL

//   Bit-serial two's-complement subtractor: DIFF = A - B - BIN, one bit per clock, LSB first.
//   It is built on a single full-subtractor cell and a borrow flip-flop.
//   It is the inverse-direction companion to the combinational full adder.
//   It sits in the lab datapath wherever a small, area-cheap multi-cycle subtract is acceptable.

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one bit per clock.
// One full-subtractor cell plus a borrow flop; start/done handshake to the controlling FSM.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             a_msb_q, b_msb_q;
  logic             accept, last;
  logic             d_bit, br_nxt;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          accept  = 1'b1;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = S_DONE;
          last    = 1'b1;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The final bit is still combinational on the last edge, so the result is
  // assembled from the cell output and the partially filled shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      br_q    <= bin;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      br_q   <= br_nxt;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        diff <= {d_bit, res_sr[WIDTH-1:1]};
        bout <= br_nxt;
        ovf  <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
      end
    end
  end
endmodule
